hawk_axird_arb: RTL
===================

HAWK_AXIRD_ARB -- requirements
Module: hawk_axird_arb

Interface
REQ-001 SHALL have parameter NUM_MSTR, default 2: number of upstream AXI read masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 64: AR address width.
REQ-003 SHALL have parameter DATA_W, default 512: R data width (one cacheline).
REQ-004 SHALL have parameter ID_W, default 6: upstream ID width.
REQ-005 SHALL have parameter MAX_OUTSTD, default 8: outstanding bursts allowed per master.
REQ-006 SHALL have parameter ARB_MODE, default ARB_RR: arbitration mode, ARB_FIXED or ARB_RR.
REQ-007 SHALL use one clock and an asynchronous, active-high reset. Port list:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- s_arvalid  in  NUM_MSTR  per-master AR valid.
- s_arready  out  NUM_MSTR  per-master AR ready.
- s_araddr  in  NUM_MSTR*ADDR_W  packed addresses; master i occupies slice i.
- s_arid  in  NUM_MSTR*ID_W  packed IDs.
- s_arlen  in  NUM_MSTR*8  packed burst lengths.
- s_rvalid  out  NUM_MSTR  routed R valid.
- s_rready  in  NUM_MSTR  per-master R ready.
- s_rdata  out  DATA_W  R data, broadcast to all masters.
- s_rid  out  ID_W  lower ID_W bits of m_rid.
- s_rresp  out  2  R response, broadcast.
- s_rlast  out  1  R last, broadcast.
- m_arvalid/m_arready  out/in  1  downstream AR handshake.
- m_araddr  out  ADDR_W  downstream address.
- m_arid  out  ID_W+IDX_W  downstream ID = {master index, s_arid}; IDX_W=clog2(NUM_MSTR).
- m_arlen  out  8  downstream burst length.
- m_rvalid/m_rready  in/out  1  downstream R handshake.
- m_rdata  in  DATA_W  downstream R data.
- m_rid  in  ID_W+IDX_W  downstream R ID.
- m_rresp  in  2  downstream R response.
- m_rlast  in  1  downstream R last.
- mstr_mask  in  NUM_MSTR  1 = master i excluded from arbitration (CPU stall override).
- rid_err  out  1  sticky flag: R beat carried an out-of-range index.

Function
REQ-008 SHALL implement an AR FSM with states IDLE and HOLD.
- IDLE: if any master is eligible, grant one, pulse its s_arready for 1 cycle, register addr/id/len, go to HOLD.
- HOLD: m_arvalid=1 with payload stable until m_arready; on handshake return to IDLE.
REQ-009 SHALL treat master i as eligible only when s_arvalid[i]=1, mstr_mask[i]=0 and its outstanding count < MAX_OUTSTD.
REQ-010 SHALL produce m_arvalid exactly 1 cycle after capture; no new grant in HOLD, so peak AR throughput is one request per 2 cycles.
REQ-011 SHALL, in ARB_FIXED mode, grant the lowest eligible index.
REQ-012 SHALL, in ARB_RR mode, search from last_grant+1 upward with modulo NUM_MSTR wrap; last_grant resets to NUM_MSTR-1, so master 0 wins first.
REQ-013 SHALL have a mask change take effect at the next IDLE evaluation; a request already in HOLD completes regardless of the mask.
REQ-014 SHALL keep one outstanding counter per master, width clog2(MAX_OUTSTD+1).
- +1 on capture.
- -1 on an R handshake with m_rlast=1 for that index.
- Both in the same cycle: unchanged.
- Never wraps.
REQ-015 SHALL route R beats combinationally.
- idx = m_rid[ID_W+IDX_W-1:ID_W].
- s_rvalid[idx] = m_rvalid; all other s_rvalid = 0.
- m_rready = s_rready[idx].
REQ-016 SHALL, when idx >= NUM_MSTR, drive m_rready=1, assert no s_rvalid, and set rid_err (cleared only by reset).
REQ-017 SHALL add no R-path latency and no R buffering.

Reset
REQ-018 SHALL, while rst=1, drive: s_arready=0, m_arvalid=0, m_araddr/m_arid/m_arlen=0, all counters=0, rid_err=0, FSM=IDLE, last_grant=NUM_MSTR-1.
REQ-019 SHALL, on reset mid-HOLD, drop m_arvalid asynchronously and discard the request; no counter state is retained.
REQ-020 SHALL resume arbitration on the first clk edge after rst deasserts.

Structure
REQ-021 SHALL take the arb mode enum (ARB_FIXED, ARB_RR) and the arb FSM state typedef from hacd_pkg.
REQ-022 SHALL place the grant logic and last_grant register in a sub-module, hawk_rr_arbiter (inputs req vector and mode; outputs one-hot grant).

Verification
REQ-023 SHALL cover: NUM_MSTR=2, RR, both masters hold s_arvalid continuously, m_arready=1 -> grants 0,1,0,1; m_arid[6]=0,1,0,1.
REQ-024 SHALL cover: ARB_FIXED, masters 0 and 1 both requesting -> master 0 granted every IDLE; master 1 granted only after mstr_mask[0]=1.
REQ-025 SHALL cover: MAX_OUTSTD=2, master 0 issues 3 requests with no R data -> third s_arready withheld; released 1 cycle after an rlast beat for idx 0.
REQ-026 SHALL cover: HOLD with m_arready=0 for 5 cycles -> m_araddr/m_arid/m_arlen stable; s_arready stays 0.
REQ-027 SHALL cover: NUM_MSTR=3, R beat with idx=3 -> m_rready=1, s_rvalid=000, rid_err=1 and stays 1.
REQ-028 SHALL cover: rst asserted during HOLD -> m_arvalid=0 in the same cycle; counters read 0; first grant after release is master 0.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared types for the AXI read-request arbiter: arbitration mode and AR FSM state.
package hacd_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/hawk_rr_arbiter.sv
// Grant selection for the AR arbiter: fixed-priority or round-robin, with the
// last-grant pointer that drives the round-robin search.
module hawk_rr_arbiter
  import hacd_pkg::*;
#(
  parameter int  NUM_MSTR = 2,
  localparam int IDX_W    = $clog2(NUM_MSTR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_MSTR-1:0] i_req,
  input  arb_mode_e           i_mode,
  input  logic                i_accept,
  output logic [NUM_MSTR-1:0] o_grant,
  output logic [IDX_W-1:0]    o_grant_idx
);

  logic [IDX_W-1:0] r_last_grant;

  // Each requester gets a search distance; the smallest distance wins. In
  // round-robin mode the distance starts just after the last grant.
  always_comb begin
    int w_dist;
    int w_best_dist;
    int w_best_idx;
    w_best_dist = NUM_MSTR;
    w_best_idx  = 0;
    o_grant     = '0;
    for (int i = 0; i < NUM_MSTR; i++) begin
      if (i_mode == ARB_RR)
        w_dist = (i + 2 * NUM_MSTR - int'(r_last_grant) - 1) % NUM_MSTR;
      else
        w_dist = i;
      if (i_req[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best_idx  = i;
      end
    end
    for (int i = 0; i < NUM_MSTR; i++)
      o_grant[i] = (w_best_dist < NUM_MSTR) && (i == w_best_idx);
    o_grant_idx = IDX_W'(w_best_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_last_grant <= IDX_W'(NUM_MSTR - 1);
    else if (i_accept)
      r_last_grant <= o_grant_idx;
  end

endmodule

// File: rtl/hawk_axird_arb.sv
// N-to-1 AXI read arbiter: grants one AR request at a time downstream, tags the
// ID with the master index, tracks per-master outstanding bursts, routes R back.
module hawk_axird_arb
  import hacd_pkg::*;
#(
  parameter int        NUM_MSTR   = 2,
  parameter int        ADDR_W     = 64,
  parameter int        DATA_W     = 512,
  parameter int        ID_W       = 6,
  parameter int        MAX_OUTSTD = 8,
  parameter arb_mode_e ARB_MODE   = ARB_RR,
  localparam int       IDX_W      = $clog2(NUM_MSTR)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_MSTR-1:0]        s_arvalid,
  output logic [NUM_MSTR-1:0]        s_arready,
  input  logic [NUM_MSTR*ADDR_W-1:0] s_araddr,
  input  logic [NUM_MSTR*ID_W-1:0]   s_arid,
  input  logic [NUM_MSTR*8-1:0]      s_arlen,
  output logic [NUM_MSTR-1:0]        s_rvalid,
  input  logic [NUM_MSTR-1:0]        s_rready,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [ID_W-1:0]            s_rid,
  output logic [1:0]                 s_rresp,
  output logic                       s_rlast,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  output logic [ADDR_W-1:0]          m_araddr,
  output logic [ID_W+IDX_W-1:0]      m_arid,
  output logic [7:0]                 m_arlen,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic [ID_W+IDX_W-1:0]      m_rid,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rlast,
  input  logic [NUM_MSTR-1:0]        mstr_mask,
  output logic                       rid_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTD + 1);

  arb_state_e            r_state, w_state_nxt;
  logic [NUM_MSTR-1:0]   w_elig, w_req, w_grant, w_inc, w_dec;
  logic [IDX_W-1:0]      w_gidx, w_ridx;
  logic                  w_capture, w_rid_ok;
  logic [ADDR_W-1:0]     w_addr_sel, r_araddr;
  logic [ID_W-1:0]       w_id_sel;
  logic [7:0]            w_len_sel, r_arlen;
  logic [ID_W+IDX_W-1:0] r_arid;
  logic [CNT_W-1:0]      r_cnt [NUM_MSTR];
  logic                  r_rid_err;

  // Requests only reach the arbiter in IDLE, and never while reset is held,
  // so s_arready is a single-cycle pulse tied to the capture edge.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_MSTR; i++)
      w_elig[i] = s_arvalid[i] && !mstr_mask[i] && (r_cnt[i] < CNT_W'(MAX_OUTSTD));
    w_req     = ((r_state == ST_IDLE) && !rst) ? w_elig : '0;
    w_capture = |w_req;
  end

  hawk_rr_arbiter #(.NUM_MSTR(NUM_MSTR)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_req),
    .i_mode     (ARB_MODE),
    .i_accept   (w_capture),
    .o_grant    (w_grant),
    .o_grant_idx(w_gidx)
  );

  always_comb begin
    w_addr_sel = '0;
    w_id_sel   = '0;
    w_len_sel  = '0;
    for (int i = 0; i < NUM_MSTR; i++) begin
      if (w_grant[i]) begin
        w_addr_sel = s_araddr[i*ADDR_W +: ADDR_W];
        w_id_sel   = s_arid[i*ID_W +: ID_W];
        w_len_sel  = s_arlen[i*8 +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_capture) w_state_nxt = ST_HOLD;
      ST_HOLD: if (m_arready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_araddr <= '0;
      r_arid   <= '0;
      r_arlen  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_araddr <= w_addr_sel;
        r_arid   <= {w_gidx, w_id_sel};
        r_arlen  <= w_len_sel;
      end
    end
  end

  // R routing is purely combinational; an index with no matching master is
  // sunk (m_rready=1) so a bad ID cannot stall the downstream channel.
  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b1;
    w_rid_ok = 1'b0;
    w_inc    = '0;
    w_dec    = '0;
    for (int i = 0; i < NUM_MSTR; i++) begin
      w_inc[i] = w_capture && w_grant[i];
      if (w_ridx == IDX_W'(i)) begin
        w_rid_ok    = 1'b1;
        s_rvalid[i] = m_rvalid;
        m_rready    = s_rready[i];
        w_dec[i]    = m_rvalid && s_rready[i] && m_rlast;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_MSTR; i++) r_cnt[i] <= '0;
      r_rid_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MSTR; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_cnt[i] != CNT_W'(MAX_OUTSTD)))
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
      if (m_rvalid && !w_rid_ok)
        r_rid_err <= 1'b1;
    end
  end

  assign w_ridx    = m_rid[ID_W+IDX_W-1:ID_W];
  assign s_arready = w_grant & {NUM_MSTR{w_capture}};
  assign m_arvalid = (r_state == ST_HOLD);
  assign m_araddr  = r_araddr;
  assign m_arid    = r_arid;
  assign m_arlen   = r_arlen;
  assign s_rdata   = m_rdata;
  assign s_rid     = m_rid[ID_W-1:0];
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;
  assign rid_err   = r_rid_err;

endmodule
